// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter sharing one clear/preset/load register between NREQ requesters,
// with bounded lock bursts and a one-cycle registered read response.
module shared_reg_arbiter #(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 8,
  parameter int LOCK_MAX = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [2*NREQ-1:0]        req_op,
  input  logic [WIDTH*NREQ-1:0]    req_data,
  input  logic [NREQ-1:0]          req_lock,
  output logic [NREQ-1:0]          req_ready,
  output logic [WIDTH-1:0]         q,
  output logic                     rd_valid,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(NREQ)-1:0]  rd_id,
  output logic                     owner_valid,
  output logic [$clog2(NREQ)-1:0]  owner_id
);

  localparam int IDW = $clog2(NREQ);

  typedef enum logic {UNLOCKED, LOCKED} lock_state_t;

  lock_state_t      state, state_nxt;
  logic [IDW-1:0]   rr_ptr, rr_ptr_nxt;
  logic [IDW-1:0]   owner_id_nxt;
  logic [3:0]       lock_cnt, lock_cnt_nxt;
  logic [4:0]       cnt_inc;
  logic [IDW-1:0]   gnt_id;
  logic [IDW-1:0]   scan_idx;
  logic             gnt_any;
  logic             owner_req;
  logic [1:0]       gnt_op;
  logic [WIDTH-1:0] gnt_data;

  function automatic logic [IDW-1:0] inc_idx(input logic [IDW-1:0] i);
    if (int'(i) == NREQ - 1) return '0;
    return i + 1'b1;
  endfunction

  assign owner_valid = (state == LOCKED);

  // Arbitration: the lock holder wins while it keeps requesting, else scan from rr_ptr
  always_comb begin
    owner_req = (state == LOCKED) && req_valid[owner_id];
    gnt_any   = 1'b0;
    gnt_id    = rr_ptr;
    scan_idx  = rr_ptr;
    if (owner_req) begin
      gnt_any = 1'b1;
      gnt_id  = owner_id;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        if (!gnt_any && req_valid[scan_idx]) begin
          gnt_any = 1'b1;
          gnt_id  = scan_idx;
        end
        scan_idx = inc_idx(scan_idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (rst && gnt_any) req_ready[gnt_id] = 1'b1;
    gnt_op   = req_op[2*gnt_id +: 2];
    gnt_data = req_data[WIDTH*gnt_id +: WIDTH];
  end

  always_comb begin
    state_nxt    = state;
    owner_id_nxt = owner_id;
    lock_cnt_nxt = lock_cnt;
    rr_ptr_nxt   = rr_ptr;
    cnt_inc      = {1'b0, lock_cnt} + 5'd1;
    if (owner_req) begin
      if (req_lock[owner_id] && int'(cnt_inc) < LOCK_MAX) begin
        lock_cnt_nxt = cnt_inc[3:0];
      end else begin
        state_nxt    = UNLOCKED;
        lock_cnt_nxt = '0;
        rr_ptr_nxt   = inc_idx(owner_id);
      end
    end else begin
      // Lock (if any) is lost because the owner stopped requesting; plain round-robin applies
      state_nxt    = UNLOCKED;
      lock_cnt_nxt = '0;
      if (gnt_any) begin
        rr_ptr_nxt = inc_idx(gnt_id);
        if (req_lock[gnt_id] && LOCK_MAX > 1) begin
          state_nxt    = LOCKED;
          owner_id_nxt = gnt_id;
          lock_cnt_nxt = 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= UNLOCKED;
      owner_id <= '0;
      lock_cnt <= '0;
      rr_ptr   <= '0;
    end else begin
      state    <= state_nxt;
      owner_id <= owner_id_nxt;
      lock_cnt <= lock_cnt_nxt;
      rr_ptr   <= rr_ptr_nxt;
    end
  end

  // Register update and read response, one edge after acceptance
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q        <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_id    <= '0;
    end else begin
      rd_valid <= 1'b0;
      if (gnt_any) begin
        case (gnt_op)
          2'b00: q <= gnt_data;
          2'b01: q <= '0;
          2'b10: q <= '1;
          default: begin
            rd_valid <= 1'b1;
            rd_data  <= q;
            rd_id    <= gnt_id;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Self-checking bench for shared_reg_arbiter: directed scenarios plus randomized traffic
// checked every cycle against a behavioural model of the arbitration and register rules.
module tb_shared_reg_arbiter;

  localparam int NREQ     = 4;
  localparam int WIDTH    = 8;
  localparam int LOCK_MAX = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NREQ-1:0]        req_valid;
  logic [2*NREQ-1:0]      req_op;
  logic [WIDTH*NREQ-1:0]  req_data;
  logic [NREQ-1:0]        req_lock;
  logic [NREQ-1:0]        req_ready;
  logic [WIDTH-1:0]       q;
  logic                   rd_valid;
  logic [WIDTH-1:0]       rd_data;
  logic [1:0]             rd_id;
  logic                   owner_valid;
  logic [1:0]             owner_id;

  shared_reg_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op), .req_data(req_data),
    .req_lock(req_lock), .req_ready(req_ready), .q(q), .rd_valid(rd_valid),
    .rd_data(rd_data), .rd_id(rd_id), .owner_valid(owner_valid), .owner_id(owner_id)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model state
  logic [7:0] m_q, m_rdd;
  bit         m_rdv, m_locked;
  int         m_rdid, m_owner, m_streak, m_ptr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q = 0; m_rdd = 0; m_rdv = 0; m_rdid = 0;
    m_locked = 0; m_owner = 0; m_streak = 0; m_ptr = 0;
  endtask

  function automatic int model_grant();
    if (m_locked && req_valid[m_owner]) return m_owner;
    for (int k = 0; k < NREQ; k++) begin
      int c;
      c = (m_ptr + k) % NREQ;
      if (req_valid[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_edge();
    int g;
    logic [1:0] op;
    g = model_grant();
    m_rdv = 0;
    if (g < 0) begin
      m_locked = 0;
      return;
    end
    op = req_op[2*g +: 2];
    case (op)
      2'b00: m_q = req_data[8*g +: 8];
      2'b01: m_q = 8'h00;
      2'b10: m_q = 8'hFF;
      default: begin m_rdv = 1; m_rdd = m_q; m_rdid = g; end
    endcase
    if (m_locked && g == m_owner) begin
      m_streak++;
      if (!req_lock[g] || m_streak >= LOCK_MAX) begin
        m_locked = 0;
        m_ptr = (g + 1) % NREQ;
      end
    end else begin
      m_locked = 0;
      m_ptr = (g + 1) % NREQ;
      if (req_lock[g] && LOCK_MAX > 1) begin
        m_locked = 1; m_owner = g; m_streak = 1;
      end
    end
  endtask

  task automatic check_all();
    int g;
    g = model_grant();
    chk("req_ready", req_ready, (g < 0) ? 0 : (1 << g));
    chk("q", q, m_q);
    chk("rd_valid", rd_valid, m_rdv);
    if (m_rdv) begin
      chk("rd_data", rd_data, m_rdd);
      chk("rd_id", rd_id, m_rdid);
    end
    chk("owner_valid", owner_valid, m_locked);
    if (m_locked) chk("owner_id", owner_id, m_owner);
  endtask

  // Called at posedge+2 with inputs set; returns at posedge+1 of the next cycle
  task automatic cycle();
    #3;
    check_all();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lock_seq[7] = '{3, 0, 1, 1, 1, 1, 2};
    rst = 1'b0; req_valid = '0; req_op = '0; req_data = '0; req_lock = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    req_valid = 4'hF;
    #1;
    chk("reset_ready", req_ready, 0);
    chk("reset_q", q, 0);
    chk("reset_rd_valid", rd_valid, 0);
    chk("reset_owner_valid", owner_valid, 0);
    req_valid = '0;
    rst = 1'b1;
    cycle();

    // Round-robin loads
    req_valid = 4'hF; req_op = 8'h00; req_data = 32'h44332211; req_lock = '0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("rr_grant", req_ready, 1 << (k % 4));
      cycle();
      chk("rr_q", q, 8'h11 * ((k % 4) + 1));
    end

    // Preset / read / clear / read from requester 2
    req_valid = 4'b0100; req_op = 8'b0010_0000;
    #1; chk("ops_grant", req_ready, 4); cycle(); chk("ops_preset_q", q, 8'hFF);
    req_op = 8'b0011_0000;
    #1; cycle();
    chk("ops_rd_valid", rd_valid, 1); chk("ops_rd_data", rd_data, 8'hFF); chk("ops_rd_id", rd_id, 2);
    req_op = 8'b0001_0000;
    #1; cycle(); chk("ops_clear_q", q, 8'h00);
    req_op = 8'b0011_0000;
    #1; cycle(); chk("ops_rd_valid2", rd_valid, 1); chk("ops_rd_data2", rd_data, 8'h00);

    // Lock bound: requester 1 holds for exactly LOCK_MAX grants
    req_valid = 4'hF; req_op = 8'hFF; req_lock = 4'b0010;
    for (int i = 0; i < 7; i++) begin
      #1;
      chk("lock_grant", req_ready, 1 << lock_seq[i]);
      cycle();
      if (i >= 2 && i <= 4) begin
        chk("lock_owner_valid", owner_valid, 1);
        chk("lock_owner_id", owner_id, 1);
      end
      if (i == 5) chk("lock_released", owner_valid, 0);
    end

    // Lock dropped when owner deasserts valid
    req_lock = 4'b1000; req_op = 8'b1111_1100; req_data = 32'h0000005A;
    #1; chk("drop_lock_grant", req_ready, 8); cycle();
    chk("drop_owner_valid", owner_valid, 1); chk("drop_owner_id", owner_id, 3);
    req_valid = 4'b0111;
    #1; chk("drop_grant0", req_ready, 1); cycle();
    chk("drop_owner_cleared", owner_valid, 0); chk("drop_q", q, 8'h5A);

    // Idle, then read and load in the same cycle
    req_valid = '0; req_lock = '0;
    #1; chk("idle_ready", req_ready, 0); cycle(); chk("idle_q", q, 8'h5A);
    req_valid = 4'b1010; req_op = 8'b0000_1100; req_data = 32'hC3000000;
    #1; chk("sim_grant_read", req_ready, 2); cycle();
    chk("sim_rd_valid", rd_valid, 1); chk("sim_rd_data", rd_data, 8'h5A); chk("sim_rd_id", rd_id, 1);
    req_valid = 4'b1000;
    #1; chk("sim_grant_load", req_ready, 8); cycle(); chk("sim_q", q, 8'hC3);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      req_valid = 4'($urandom_range(0, 15));
      req_op    = 8'($urandom);
      req_data  = $urandom;
      req_lock  = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
      #1;
      cycle();
    end

    // Asynchronous reset mid-cycle with a lock held and a read response pending
    req_valid = 4'b0100; req_lock = 4'b0100; req_op = 8'b0000_0000; req_data = 32'h00A50000;
    #1; cycle();
    req_op = 8'b0011_0000;
    #1; cycle();
    chk("pre_reset_rd_valid", rd_valid, 1);
    chk("pre_reset_q", q, 8'hA5);
    #2 rst = 1'b0;
    #1;
    chk("async_q", q, 0);
    chk("async_ready", req_ready, 0);
    chk("async_rd_valid", rd_valid, 0);
    chk("async_owner_valid", owner_valid, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1; req_valid = 4'hF; req_lock = '0; req_op = 8'hFF;
    #1; chk("post_reset_grant", req_ready, 1);
    cycle();
    req_valid = '0;
    #1; cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
